// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch queue bundle: redirect, imem request/response, decode handoff
interface if_fetch_queue_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic              imem_req_valid;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_req_ready;
   logic              imem_rsp_valid;
   logic [DATA_W-1:0] imem_rsp_data;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;
   logic [CNT_W-1:0]  queue_count;

   modport master (
      input  redirect_valid, redirect_addr, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, instr_ready,
      output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
             queue_count
   );

   modport slave (
      output redirect_valid, redirect_addr, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, instr_ready,
      input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc,
             queue_count
   );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch front end with credit-limited requests and instruction queue
module if_fetch_queue #(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic            clk,
   input logic            rst,
   if_fetch_queue_if.master io_bus
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int SUM_W  = CNT_W + 1;

   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_rsp_pc;
   logic [DATA_W-1:0] r_q_data [DEPTH];
   logic [ADDR_W-1:0] r_q_pc   [DEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_outstanding;
   logic [CNT_W-1:0]  r_drop;

   logic [SUM_W-1:0]  w_inflight;
   logic              w_req_valid;
   logic              w_req_hs;
   logic              w_instr_valid;
   logic              w_pop;
   logic              w_keep;
   logic [CNT_W-1:0]  w_out_next;
   logic [ADDR_W-1:0] w_redirect_pc;

   // Queue slots plus outstanding requests form the credit pool, so every response has a slot.
   assign w_inflight    = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_req_valid   = !rst && (w_inflight < SUM_W'(DEPTH));
   assign w_req_hs      = w_req_valid && io_bus.imem_req_ready;
   assign w_instr_valid = !rst && (r_count != '0);
   assign w_pop         = w_instr_valid && io_bus.instr_ready;
   assign w_keep        = io_bus.imem_rsp_valid && (r_drop == '0);
   assign w_out_next    = r_outstanding + CNT_W'(w_req_hs) - CNT_W'(io_bus.imem_rsp_valid);
   assign w_redirect_pc = {io_bus.redirect_addr[ADDR_W-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_data[i] <= '0;
            r_q_pc[i]   <= '0;
         end
      end else if (io_bus.redirect_valid) begin
         // Everything still in flight after this edge belongs to the old path.
         r_fetch_pc    <= w_redirect_pc;
         r_rsp_pc      <= w_redirect_pc;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= w_out_next;
         r_drop        <= w_out_next;
      end else begin
         r_outstanding <= w_out_next;
         if (w_req_hs) begin
            r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
         end
         if (io_bus.imem_rsp_valid && (r_drop != '0)) begin
            r_drop <= r_drop - CNT_W'(1);
         end
         if (w_keep) begin
            r_q_data[r_wr_ptr] <= io_bus.imem_rsp_data;
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
            r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
            r_rsp_pc           <= r_rsp_pc + ADDR_W'(4);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_keep) - CNT_W'(w_pop);
      end
   end

   assign io_bus.imem_req_valid = w_req_valid;
   assign io_bus.imem_req_addr  = r_fetch_pc;
   assign io_bus.instr_valid    = w_instr_valid;
   assign io_bus.instr_data     = r_q_data[r_rd_ptr];
   assign io_bus.instr_pc       = r_q_pc[r_rd_ptr];
   assign io_bus.queue_count    = r_count;
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;
   localparam int          ADDR_W   = 32;
   localparam int          DATA_W   = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      int          due;
      logic [31:0] addr;
      int          epoch;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   lat;
   int   last_due;
   int   epoch;
   int   m_count;
   logic [31:0] m_fetch;
   bit   after_rst;
   int   checks;
   int   failures;
   mreq_t pend[$];
   exp_t  sb[$];

   if_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   if_fetch_queue #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: in-order, fixed latency per request, never back-pressures responses.
   always @(posedge clk) begin
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
      end
   end

   // Monitor and reference model: everything sampled mid-cycle, model advanced for the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
         chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
         pend.delete();
         sb.delete();
         m_count   = 0;
         m_fetch   = RESET_PC;
         last_due  = 0;
         epoch     = epoch + 1;
         after_rst = 1'b1;
      end else begin
         bit   m_req_valid;
         if (after_rst) begin
            chk("post_rst_instr_data", bus.instr_data, 32'd0);
            chk("post_rst_instr_pc", bus.instr_pc, 32'd0);
            chk("post_rst_req_addr", bus.imem_req_addr, RESET_PC);
            after_rst = 1'b0;
         end
         m_req_valid = (m_count + pend.size()) < DEPTH;
         chk("queue_count", 32'(bus.queue_count), 32'(m_count));
         chk("instr_valid", 32'(bus.instr_valid), 32'(m_count != 0));
         chk("req_valid", 32'(bus.imem_req_valid), 32'(m_req_valid));
         if (m_req_valid) chk("req_addr", bus.imem_req_addr, m_fetch);

         if (m_count > 0 && bus.instr_ready) begin
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_underflow actual=empty required=entry cycle=%0d", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("instr_pc", bus.instr_pc, e.pc);
               chk("instr_data", bus.instr_data, e.data);
            end
            m_count--;
         end

         if (bus.imem_rsp_valid && pend.size() > 0) begin
            mreq_t r;
            r = pend.pop_front();
            if (r.epoch == epoch && !bus.redirect_valid) begin
               m_count++;
               if (m_count > DEPTH) begin
                  failures++;
                  $display("FAIL queue_overflow actual=%0d required<=%0d cycle=%0d", m_count, DEPTH, cyc);
               end
            end
         end

         if (m_req_valid && bus.imem_req_ready) begin
            mreq_t r;
            exp_t  e;
            r.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            r.addr   = bus.imem_req_addr;
            r.epoch  = epoch;
            last_due = r.due;
            pend.push_back(r);
            e.pc   = m_fetch;
            e.data = mem_word(m_fetch);
            sb.push_back(e);
            m_fetch = m_fetch + 32'd4;
         end

         if (bus.redirect_valid) begin
            epoch   = epoch + 1;
            sb.delete();
            m_count = 0;
            m_fetch = {bus.redirect_addr[31:2], 2'b00};
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] a);
      bus.redirect_addr  = a;
      bus.redirect_valid = 1'b1;
      step(1);
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      epoch    = 0;
      m_count  = 0;
      m_fetch  = RESET_PC;
      last_due = 0;
      lat      = 1;
      rst      = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = '0;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      step(2);
      rst = 1'b0;
      step(20);

      bus.instr_ready = 1'b0;
      step(12);
      bus.instr_ready = 1'b1;
      step(10);

      lat = 3;
      step(6);
      redirect(32'h0000_0103);
      step(15);

      lat = 1;
      redirect(32'hFFFF_FFF8);
      step(10);

      // Fill the queue partially with requests in flight, then reset mid-stream.
      lat = 2;
      bus.instr_ready = 1'b0;
      redirect(32'h0000_0200);
      step(4);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      bus.instr_ready = 1'b1;
      step(10);

      for (int i = 0; i < 3000; i++) begin
         bus.imem_req_ready = ($urandom_range(0, 3) != 0);
         bus.instr_ready    = ($urandom_range(0, 3) != 0);
         bus.redirect_valid = ($urandom_range(0, 24) == 0);
         bus.redirect_addr  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                           : $urandom;
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 99) == 0) lat = $urandom_range(1, 4);
         step(1);
      end
      rst = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      step(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
